// File: rtl/bus_ctrl_6502.sv
// 6502 system-bus controller: page decode, wait states, read mux, pclk, irq.
// Define BUS_ERR_EN to trap unmapped pages instead of aliasing DEFAULT_SLOT.
module bus_ctrl_6502 #(
  parameter int NSLOT = 4,
  parameter logic [4*NSLOT-1:0] SLOT_PAGE = 16'hF210,
  parameter logic [4*NSLOT-1:0] SLOT_WS = 16'h0000,
  parameter int DEFAULT_SLOT = NSLOT-1,
  parameter int CLK_FREQ = 40000000,
  parameter int PERIPH_FREQ = 4000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      cpu_ab,
  input  logic             cpu_we_n,
  output logic [7:0]       cpu_di,
  output logic             rdy,
  input  logic [NSLOT*8-1:0] slot_do,
  output logic [NSLOT-1:0] cs_n,
  output logic             slot_we_n,
  input  logic [NSLOT-1:0] irq_n_in,
  output logic             cpu_irq_n,
  output logic             pclk,
  output logic             bus_err,
  input  logic             bus_err_clr
);

  localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int PCNT = CLK_FREQ / PERIPH_FREQ;
  localparam int PW = $clog2(PCNT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    ws;
  logic [SW-1:0] hit_sel;
  logic [SW-1:0] sel;
  logic [SW-1:0] mux_sel;
  logic          hit_any;
  logic          unmapped;
  logic          err_q;
  logic [PW-1:0] pc_q;
  logic          unused_ab;

  assign unused_ab = ^cpu_ab[11:0];

  // Scan downward so the lowest matching slot is the last one written.
  always_comb begin
    hit_any = 1'b0;
    hit_sel = '0;
    for (int i = NSLOT-1; i >= 0; i--) begin
      if (cpu_ab[15:12] == SLOT_PAGE[4*i +: 4]) begin
        hit_any = 1'b1;
        hit_sel = SW'(i);
      end
    end
  end

`ifdef BUS_ERR_EN
  assign unmapped = ~hit_any;
  assign sel = hit_sel;
  assign ws = unmapped ? 4'd0 : SLOT_WS[4*int'(sel) +: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_err <= 1'b0;
    end else if (unmapped && rdy) begin
      bus_err <= 1'b1;
    end else if (bus_err_clr) begin
      bus_err <= 1'b0;
    end
  end
`else
  logic unused_clr;

  assign unused_clr = bus_err_clr;
  assign unmapped = 1'b0;
  assign sel = hit_any ? hit_sel : SW'(DEFAULT_SLOT);
  assign ws = SLOT_WS[4*int'(sel) +: 4];
  assign bus_err = 1'b0;
`endif

  always_comb begin
    cs_n = '1;
    if (!unmapped) cs_n[sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ws != 4'd0) begin
            cnt   <= ws - 4'd1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (!reset_n) rdy = 1'b1;
    else if (state == S_IDLE) rdy = (ws == 4'd0);
    else rdy = (cnt == 4'd0);
  end

  // Reset forces rdy high; keep that from looking like a write strobe.
  assign slot_we_n = cpu_we_n | ~rdy | ~reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mux_sel <= SW'(DEFAULT_SLOT);
      err_q   <= 1'b0;
    end else if (rdy) begin
      mux_sel <= sel;
      err_q   <= unmapped;
    end
  end

  assign cpu_di = err_q ? 8'hFF : slot_do[8*int'(mux_sel) +: 8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else if (pc_q == PW'(PCNT-1)) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_q + PW'(1);
    end
  end

  assign pclk = (pc_q == PW'(PCNT-1));

  assign cpu_irq_n = &irq_n_in;

endmodule

// File: tb/tb_bus_ctrl_6502.sv
// Bench for bus_ctrl_6502: directed plan items plus random accesses
// checked against a per-access reference model.
module tb_bus_ctrl_6502;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_ab;
  logic        cpu_we_n;
  logic [7:0]  cpu_di;
  logic        rdy;
  logic [31:0] slot_do;
  logic [3:0]  cs_n;
  logic        slot_we_n;
  logic [3:0]  irq_n_in;
  logic        cpu_irq_n;
  logic        pclk;
  logic        bus_err;
  logic        bus_err_clr;

  logic [7:0]  ovl_di;
  logic        ovl_rdy;
  logic [3:0]  ovl_cs_n;
  logic        ovl_we_n;
  logic        ovl_irq_n;
  logic        ovl_pclk;
  logic        ovl_err;

  int checks = 0;
  int errors = 0;
  logic berr = 1'b0;

  int page_of[4] = '{0, 1, 2, 15};
  int ws_of[4]   = '{0, 3, 5, 0};

  always #5 clk = ~clk;

  bus_ctrl_6502 #(
    .SLOT_WS(16'h0530)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_we_n(cpu_we_n),
    .cpu_di(cpu_di), .rdy(rdy), .slot_do(slot_do), .cs_n(cs_n),
    .slot_we_n(slot_we_n), .irq_n_in(irq_n_in), .cpu_irq_n(cpu_irq_n),
    .pclk(pclk), .bus_err(bus_err), .bus_err_clr(bus_err_clr)
  );

  bus_ctrl_6502 #(
    .SLOT_PAGE(16'h0000)
  ) u_ovl (
    .clk(clk), .reset_n(reset_n), .cpu_ab(cpu_ab), .cpu_we_n(cpu_we_n),
    .cpu_di(ovl_di), .rdy(ovl_rdy), .slot_do(slot_do), .cs_n(ovl_cs_n),
    .slot_we_n(ovl_we_n), .irq_n_in(irq_n_in), .cpu_irq_n(ovl_irq_n),
    .pclk(ovl_pclk), .bus_err(ovl_err), .bus_err_clr(bus_err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s ab=%h got=%h exp=%h", tag, cpu_ab, got, exp);
    end
  endtask

  task automatic do_access(input logic [15:0] a, input logic we,
                           input logic [31:0] d, input logic [3:0] irq,
                           input logic clr);
    int s;
    int n;
    logic [7:0] ed;
    logic [3:0] ecs;
    logic [3:0] eov;
    cpu_ab = a;
    cpu_we_n = we;
    slot_do = d;
    irq_n_in = irq;
    bus_err_clr = clr;
    s = -1;
    for (int i = 0; i < 4; i++)
      if (s < 0 && int'(a[15:12]) == page_of[i]) s = i;
`ifdef BUS_ERR_EN
    eov = (a[15:12] == 4'h0) ? 4'b1110 : 4'b1111;
    n = 0;
    ecs = 4'b1111;
    ed = 8'hFF;
    if (s < 0) berr = 1'b1;
    else if (clr) berr = 1'b0;
`else
    eov = (a[15:12] == 4'h0) ? 4'b1110 : 4'b0111;
    if (s < 0) s = 3;
    berr = 1'b0;
`endif
    if (s >= 0) begin
      n = ws_of[s];
      ecs = ~(4'b0001 << s);
      ed = d[8*s +: 8];
    end
    #1;
    chk("irq", 32'(cpu_irq_n), 32'(irq == 4'hF));
    chk("ovl_cs", 32'(ovl_cs_n), 32'(eov));
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("cs_n", 32'(cs_n), 32'(ecs));
      chk("rdy", 32'(rdy), 32'(k == n));
      chk("we_n", 32'(slot_we_n), 32'(we | (k != n)));
    end
    @(negedge clk);
    chk("cpu_di", 32'(cpu_di), 32'(ed));
    chk("bus_err", 32'(bus_err), 32'(berr));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    cpu_ab = 16'h0000;
    cpu_we_n = 1'b1;
    slot_do = 32'h44332211;
    irq_n_in = 4'hF;
    bus_err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_di", 32'(cpu_di), 32'h44);
    chk("rst_pclk", 32'(pclk), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      #1;
      chk("pclk", 32'(pclk), 32'((c % 10) == 9));
      @(negedge clk);
    end

    do_access(16'h0123, 1'b1, 32'h000000A5, 4'hF, 1'b0);
    do_access(16'h1004, 1'b0, 32'h12345678, 4'b1011, 1'b0);
    do_access(16'h5000, 1'b1, 32'hCAFEBABE, 4'hF, 1'b0);
    do_access(16'h0ABC, 1'b1, 32'h0000005A, 4'hF, 1'b0);
    do_access(16'h7000, 1'b1, 32'h11223344, 4'hF, 1'b1);
    do_access(16'h2000, 1'b1, 32'h00C30000, 4'hF, 1'b1);
    do_access(16'hF000, 1'b0, 32'h9C000000, 4'hE, 1'b0);

    cpu_ab = 16'h2000;
    cpu_we_n = 1'b0;
    #1;
    chk("mw_rdy0", 32'(rdy), 32'd0);
    @(negedge clk);
    #1;
    chk("mw_rdy1", 32'(rdy), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mw_rst_rdy", 32'(rdy), 32'd1);
    chk("mw_rst_we", 32'(slot_we_n), 32'd1);
    @(negedge clk);
    #1;
    chk("mw_hold_we", 32'(slot_we_n), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    berr = 1'b0;
    do_access(16'h2000, 1'b0, 32'h00770000, 4'hF, 1'b0);

    for (int t = 0; t < 300; t++) begin
      logic [15:0] a;
      logic [3:0] irq;
      a = 16'($urandom);
      irq = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      do_access(a, 1'($urandom), $urandom, irq, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
